quick_spi_master: RTL and testbench

Parametrised SPI master for the QuickSPI family. It supports all four SPI modes selected per transfer, a runtime SCLK divider and configurable data width and slave count. Each transfer has three parts: a write phase, an optional turnaround gap of free-running SCLK periods, and a read phase. It sits between a register/command front end and the external SPI pins, and exposes a start/busy/done handshake.

---
 rtl/quick_spi_master.sv | 203 ++++++++++++++++++++
 tb/tb_quick_spi_master.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/quick_spi_master.sv
// SPI master: write phase, optional free-running turnaround gap, read phase; all four modes.
// Optional macro QUICK_SPI_LSB_FIRST_EN adds the lsb_first input for LSB-first transfers.
module quick_spi_master #(
  parameter int NUM_SLAVES = 2,
  parameter int DATA_WIDTH = 16,
  parameter int SEL_W      = 1,
  parameter int LEN_W      = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [SEL_W-1:0]      slave_sel,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [7:0]            clk_div,
  input  logic [LEN_W-1:0]      tx_len,
  input  logic [LEN_W-1:0]      rx_len,
  input  logic [7:0]            gap,
  input  logic [DATA_WIDTH-1:0] tx_data,
`ifdef QUICK_SPI_LSB_FIRST_EN
  input  logic                  lsb_first,
`endif
  input  logic                  miso,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  sclk,
  output logic                  mosi,
  output logic [NUM_SLAVES-1:0] ss_n
);

  // Handshake: start is accepted only in IDLE; busy rises on the accepting edge and
  // falls together with the single-cycle done pulse; a start while busy is dropped.
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_WRITE, S_GAP, S_READ, S_HOLD
  } state_t;

  localparam int CNT_W = (LEN_W > 8) ? LEN_W : 8;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_WIDTH);

  state_t state_q, state_d;
  state_t after_setup, after_write, after_gap;

  logic [7:0]            hcnt_q, div_q, gap_q;
  logic                  half_q, cpol_q, cpha_q;
  logic [CNT_W-1:0]      cnt_q, seg_len;
  logic [LEN_W-1:0]      tx_q, rx_q, tx_c, rx_c;
  logic [DATA_WIDTH-1:0] tx_sh_q, rx_sh_q, tx_load, rx_result;
  logic [NUM_SLAVES-1:0] ss_dec;
  logic                  tick, in_bit, lead, trail;
`ifdef QUICK_SPI_LSB_FIRST_EN
  logic                  lsb_q;
  logic [DATA_WIDTH-1:0] rx_rev;
`endif

  assign tx_c   = (tx_len > MAX_LEN) ? MAX_LEN : tx_len;
  assign rx_c   = (rx_len > MAX_LEN) ? MAX_LEN : rx_len;
  assign tick   = (hcnt_q == div_q);
  assign in_bit = (state_q == S_WRITE) || (state_q == S_GAP) || (state_q == S_READ);

  assign after_gap   = (rx_q != '0) ? S_READ : S_HOLD;
  assign after_write = (gap_q != 8'd0 && rx_q != '0) ? S_GAP : after_gap;
  assign after_setup = (tx_q != '0) ? S_WRITE : after_write;

  // Transmit word pre-aligned so the first bit to send sits at the MSB.
  always_comb begin
    tx_load = tx_data << (DATA_WIDTH - int'(tx_c));
`ifdef QUICK_SPI_LSB_FIRST_EN
    if (lsb_first) begin
      for (int i = 0; i < DATA_WIDTH; i++) tx_load[DATA_WIDTH-1-i] = tx_data[i];
    end
`endif
  end

  always_comb begin
    rx_result = rx_sh_q;
`ifdef QUICK_SPI_LSB_FIRST_EN
    for (int i = 0; i < DATA_WIDTH; i++) rx_rev[DATA_WIDTH-1-i] = rx_sh_q[i];
    if (lsb_q) rx_result = rx_rev >> (DATA_WIDTH - int'(rx_q));
`endif
  end

  always_comb begin
    ss_dec = '1;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (int'(slave_sel) == i) ss_dec[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SETUP;
      S_SETUP: if (tick) state_d = after_setup;
      S_WRITE: if (tick && half_q && cnt_q == CNT_W'(1)) state_d = after_write;
      S_GAP:   if (tick && half_q && cnt_q == CNT_W'(1)) state_d = after_gap;
      S_READ:  if (tick && half_q && cnt_q == CNT_W'(1)) state_d = S_HOLD;
      S_HOLD:  if (tick) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A leading edge starts every bit, whether it continues a phase or opens the next one.
  assign lead  = tick && (state_q == S_SETUP || (in_bit && half_q)) &&
                 (state_d == S_WRITE || state_d == S_GAP || state_d == S_READ);
  assign trail = tick && in_bit && !half_q;

  always_comb begin
    case (state_d)
      S_WRITE: seg_len = CNT_W'(tx_q);
      S_GAP:   seg_len = CNT_W'(gap_q);
      S_READ:  seg_len = CNT_W'(rx_q);
      default: seg_len = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hcnt_q  <= '0;
      half_q  <= 1'b0;
      cnt_q   <= '0;
      div_q   <= '0;
      gap_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
`ifdef QUICK_SPI_LSB_FIRST_EN
      lsb_q   <= 1'b0;
`endif
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      ss_n    <= '1;
    end else begin
      done <= 1'b0;
      if (state_q == S_IDLE) begin
        sclk   <= cpol;
        mosi   <= 1'b0;
        hcnt_q <= '0;
        half_q <= 1'b0;
        if (start) begin
          cpol_q  <= cpol;
          cpha_q  <= cpha;
          div_q   <= clk_div;
          gap_q   <= gap;
          tx_q    <= tx_c;
          rx_q    <= rx_c;
`ifdef QUICK_SPI_LSB_FIRST_EN
          lsb_q   <= lsb_first;
`endif
          tx_sh_q <= cpha ? tx_load : (tx_load << 1);
          mosi    <= (!cpha && tx_c != '0) ? tx_load[DATA_WIDTH-1] : 1'b0;
          rx_sh_q <= '0;
          busy    <= 1'b1;
          ss_n    <= ss_dec;
        end
      end else begin
        hcnt_q <= tick ? 8'd0 : hcnt_q + 8'd1;
        if (lead) begin
          sclk   <= ~cpol_q;
          half_q <= 1'b0;
          cnt_q  <= (state_d == state_q) ? cnt_q - CNT_W'(1) : seg_len;
          if (state_d == S_WRITE) begin
            if (cpha_q) begin
              mosi    <= tx_sh_q[DATA_WIDTH-1];
              tx_sh_q <= tx_sh_q << 1;
            end
          end else begin
            mosi <= 1'b0;
          end
          if (state_d == S_READ && !cpha_q) rx_sh_q <= {rx_sh_q[DATA_WIDTH-2:0], miso};
        end
        if (trail) begin
          sclk   <= cpol_q;
          half_q <= 1'b1;
          if (state_q == S_WRITE && !cpha_q) begin
            mosi    <= (cnt_q != CNT_W'(1)) ? tx_sh_q[DATA_WIDTH-1] : 1'b0;
            tx_sh_q <= tx_sh_q << 1;
          end
          if (state_q == S_READ && cpha_q) rx_sh_q <= {rx_sh_q[DATA_WIDTH-2:0], miso};
        end
        if (state_q == S_HOLD && tick) begin
          done    <= 1'b1;
          busy    <= 1'b0;
          ss_n    <= '1;
          mosi    <= 1'b0;
          rx_data <= rx_result;
        end
      end
    end
  end

endmodule

// File: tb/tb_quick_spi_master.sv
// Self-checking bench for quick_spi_master: per-cycle comparison against a timing model
// derived from the transfer-length formula, plus hand-computed literal expectations.
module tb_quick_spi_master;
  localparam int NS = 2;
  localparam int W  = 16;
  localparam int SW = 2;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [SW-1:0] slave_sel = '0;
  logic          cpol = 1'b0;
  logic          cpha = 1'b0;
  logic [7:0]    clk_div = '0;
  logic [LW-1:0] tx_len = '0;
  logic [LW-1:0] rx_len = '0;
  logic [7:0]    gap = '0;
  logic [W-1:0]  tx_data = '0;
`ifdef QUICK_SPI_LSB_FIRST_EN
  logic          lsb_first = 1'b0;
`endif
  logic          miso = 1'b0;
  logic          busy, done, sclk, mosi;
  logic [W-1:0]  rx_data;
  logic [NS-1:0] ss_n;

  quick_spi_master #(.NUM_SLAVES(NS), .DATA_WIDTH(W), .SEL_W(SW), .LEN_W(LW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .slave_sel(slave_sel),
    .cpol(cpol), .cpha(cpha), .clk_div(clk_div), .tx_len(tx_len), .rx_len(rx_len),
    .gap(gap), .tx_data(tx_data),
`ifdef QUICK_SPI_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .miso(miso), .busy(busy), .done(done), .rx_data(rx_data),
    .sclk(sclk), .mosi(mosi), .ss_n(ss_n)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state
  int           n_checks = 0;
  int           n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_rx = '0;
  logic         cap_q[$];
  int           rise_cnt, ss_low, done_k;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] cap_val(input int nb);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < nb && i < cap_q.size(); i++) v = {v[W-2:0], cap_q[i]};
    return v;
  endfunction

  // One transfer. k counts clk edges after the accepting edge 0; outputs are sampled
  // 1 time unit after edge k. The slave model presents read bit j during the H cycles
  // before its sampling edge and random data elsewhere, so a wrong sample edge shows up.
  task automatic run_xfer(input logic [SW-1:0] sel, input logic pol, input logic pha,
                          input logic [7:0] div, input logic [LW-1:0] txl,
                          input logic [LW-1:0] rxl, input logic [7:0] gp_in,
                          input logic [W-1:0] data, input logic lsb, input bit use_fixed,
                          input logic [W-1:0] fixed_rx, input bit poke);
    int h, tc, rc, gp, n, ws, wend, hs, rs, dr, bi, sj;
    logic          rbits [W];
    logic [W-1:0]  exp_rx;
    logic [NS-1:0] exp_ss;
    logic          exp_sclk, exp_mosi, mo_chk, prev_sclk, lsb_e, set_miso;
`ifdef QUICK_SPI_LSB_FIRST_EN
    lsb_e = lsb;
`else
    lsb_e = 1'b0 & lsb;
`endif
    h    = int'(div) + 1;
    tc   = (int'(txl) > W) ? W : int'(txl);
    rc   = (int'(rxl) > W) ? W : int'(rxl);
    gp   = (rc != 0) ? int'(gp_in) : 0;
    n    = tc + gp + rc;
    ws   = h;
    wend = ws + 2 * h * tc;
    hs   = ws + 2 * h * n;
    rs   = ws + 2 * h * (tc + gp);
    dr   = h * (2 + 2 * n);
    exp_rx = '0;
    for (int j = 0; j < rc; j++) begin
      rbits[j] = use_fixed ? fixed_rx[rc-1-j] : 1'($urandom_range(0, 1));
      if (lsb_e) exp_rx[j] = rbits[j];
      else       exp_rx[rc-1-j] = rbits[j];
    end
    exp_q.push_back(exp_rx);
    exp_ss = '1;
    if (int'(sel) < NS) exp_ss[sel] = 1'b0;

    slave_sel = sel; cpol = pol; cpha = pha; clk_div = div; tx_len = txl; rx_len = rxl;
    gap = gp_in; tx_data = data;
`ifdef QUICK_SPI_LSB_FIRST_EN
    lsb_first = lsb;
`endif
    start = 1'b1;
    miso = 1'($urandom_range(0, 1));
    rise_cnt = 0; ss_low = 0; done_k = -1; cap_q.delete();
    prev_sclk = pol;

    for (int k = 0; k <= dr; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        start = 1'b0;
        slave_sel = SW'($urandom); cpol = 1'($urandom); cpha = 1'($urandom);
        clk_div = 8'($urandom); tx_len = LW'($urandom); rx_len = LW'($urandom);
        gap = 8'($urandom); tx_data = W'($urandom);
      end
      if (poke && k == 1 && dr > 3) start = 1'b1;
      if (k == 2) start = 1'b0;

      if (k < dr) begin
        check("busy", busy, 1'b1);
        check("done_early", done, 1'b0);
        check("ss_n", ss_n, exp_ss);
        check("rx_hold", rx_data, last_rx);
        exp_sclk = (k >= ws && k < hs && ((k - ws) / h) % 2 == 0) ? ~pol : pol;
        check("sclk", sclk, exp_sclk);
        mo_chk = 1'b1;
        exp_mosi = 1'b0;
        bi = -1;
        if (k >= hs) mo_chk = 1'b0;
        else if (!pha && tc > 0 && k < wend - h) bi = k / (2 * h);
        else if (pha && k >= ws && k < wend) bi = (k - ws) / (2 * h);
        if (bi >= 0) exp_mosi = lsb_e ? data[bi] : data[tc-1-bi];
        if (mo_chk) check("mosi", mosi, exp_mosi);
      end else begin
        check("done", done, 1'b1);
        check("busy_end", busy, 1'b0);
        check("ss_n_end", ss_n, {NS{1'b1}});
        check("sclk_end", sclk, pol);
        last_rx = exp_q.pop_front();
        check("rx_data", rx_data, last_rx);
      end

      if (done && done_k < 0) done_k = k;
      if (k > 0 && sclk !== prev_sclk) begin
        if (sclk) rise_cnt++;
        if (pha ? (sclk == pol) : (sclk != pol)) cap_q.push_back(mosi);
      end
      prev_sclk = sclk;
      if (ss_n !== {NS{1'b1}}) ss_low++;

      set_miso = 1'b0;
      for (int j = 0; j < rc; j++) begin
        sj = rs + 2 * h * j + (pha ? h : 0);
        if (sj - h <= k && k < sj) begin
          miso = rbits[j];
          set_miso = 1'b1;
        end
      end
      if (!set_miso) miso = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic reset_mid_write();
    cpol = 1'b1; cpha = 1'b0; clk_div = 8'd1; tx_len = 5'd16; rx_len = 5'd4; gap = 8'd1;
    tx_data = W'($urandom); slave_sel = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("busy_before_reset", busy, 1'b1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("rst_sclk", sclk, 1'b0);
    check("rst_ss_n", ss_n, {NS{1'b1}});
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_rx_data", rx_data, '0);
    last_rx = '0;
    reset_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      check("no_done_after_reset", done, 1'b0);
      check("no_busy_after_reset", busy, 1'b0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_rx_data", rx_data, '0);
    check("reset_sclk", sclk, 1'b0);
    check("reset_mosi", mosi, 1'b0);
    check("reset_ss_n", ss_n, {NS{1'b1}});
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Mode 0, H=2, 16-bit write of 0xA55A: done seen at edge 1+2*(2+32)=69
    run_xfer(2'd0, 1'b0, 1'b0, 8'd1, 5'd16, 5'd0, 8'd0, 16'hA55A, 1'b0, 1'b0, '0, 1'b0);
    check("m0_mosi_seq", cap_val(16), 16'hA55A);
    check("m0_rises", rise_cnt, 16);
    check("m0_done_edge", done_k + 1, 69);

    // Mode 3, write 0x1A, 2 gap periods, read 9 bits 1_0110_1010, slave 1
    run_xfer(2'd1, 1'b1, 1'b1, 8'd1, 5'd8, 5'd9, 8'd2, 16'h001A, 1'b0, 1'b1, 16'h016A, 1'b0);
    check("m3_rx", rx_data, 16'h016A);
    check("m3_rises", rise_cnt, 19);
    check("m3_mosi_seq", cap_val(8), 16'h001A);

    // Modes 1 and 2 at clk_div=0
    run_xfer(2'd0, 1'b0, 1'b1, 8'd0, 5'd4, 5'd4, 8'd0, 16'h000B, 1'b0, 1'b0, '0, 1'b0);
    check("m1_mosi_seq", cap_val(4), 16'h000B);
    run_xfer(2'd1, 1'b1, 1'b0, 8'd0, 5'd4, 5'd4, 8'd0, 16'h0006, 1'b0, 1'b0, '0, 1'b0);
    check("m2_mosi_seq", cap_val(4), 16'h0006);

    // Empty transfer: select held for 2H = 6 cycles
    run_xfer(2'd0, 1'b0, 1'b0, 8'd2, 5'd0, 5'd0, 8'd3, 16'hFFFF, 1'b0, 1'b0, '0, 1'b0);
    check("empty_ss_low", ss_low, 6);

    // Clamp 31 -> 16; gap ignored without a read phase; start poked while busy
    run_xfer(2'd1, 1'b0, 1'b0, 8'd0, 5'd31, 5'd0, 8'd5, 16'h1234, 1'b0, 1'b0, '0, 1'b1);
    check("clamp_rises", rise_cnt, 16);

    // Out-of-range select: no line asserts
    run_xfer(2'd2, 1'b0, 1'b1, 8'd1, 5'd3, 5'd3, 8'd1, 16'h0005, 1'b0, 1'b0, '0, 1'b0);
    check("bad_sel_ss_low", ss_low, 0);

`ifdef QUICK_SPI_LSB_FIRST_EN
    run_xfer(2'd0, 1'b0, 1'b0, 8'd1, 5'd8, 5'd5, 8'd0, 16'h0001, 1'b1, 1'b0, '0, 1'b0);
    check("lsb_mosi_seq", cap_val(8), 16'h0080);
`endif

    for (int t = 0; t < 30; t++) begin
      run_xfer(SW'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
               8'($urandom_range(0, 3)), LW'($urandom_range(0, 20)),
               LW'($urandom_range(0, 20)), 8'($urandom_range(0, 3)), W'($urandom),
               1'($urandom), 1'b0, '0, 1'($urandom));
    end

    reset_mid_write();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
